// File: rtl/cmd_cfg_pkg.sv
// Shared opcodes, FSM encodings, register map and response codes for the host command engine.
package cmd_cfg_pkg;

    typedef enum logic [1:0] {
        OP_RD   = 2'b00,
        OP_WR   = 2'b01,
        OP_DUMP = 2'b10,
        OP_NAK  = 2'b11
    } op_e;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t RD_WAIT = 2'd1;
    localparam state_t SEND    = 2'd2;
    localparam state_t RESP    = 2'd3;

    localparam logic [5:0] A_TRIG_CFG   = 6'h00;
    localparam logic [5:0] A_DECIM      = 6'h10;
    localparam logic [5:0] A_VIH        = 6'h11;
    localparam logic [5:0] A_VIL        = 6'h12;
    localparam logic [5:0] A_MATCH_H    = 6'h13;
    localparam logic [5:0] A_MATCH_L    = 6'h14;
    localparam logic [5:0] A_MASK_H     = 6'h15;
    localparam logic [5:0] A_MASK_L     = 6'h16;
    localparam logic [5:0] A_BAUD_H     = 6'h17;
    localparam logic [5:0] A_BAUD_L     = 6'h18;
    localparam logic [5:0] A_TRIG_POS_H = 6'h19;
    localparam logic [5:0] A_TRIG_POS_L = 6'h1A;
    localparam logic [5:0] A_DUMP_LEN_H = 6'h1B;
    localparam logic [5:0] A_DUMP_LEN_L = 6'h1C;

    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'hEE;

endpackage

// File: rtl/cmd_cfg_multi_if.sv
// UART command/response handshake plus RAMqueue read port; master is the host side, slave the engine.
interface cmd_cfg_multi_if #(
    parameter int LOG2   = 9,
    parameter int NUM_CH = 5
);
    logic [15:0]         cmd;
    logic                cmd_rdy;
    logic                resp_sent;
    logic [LOG2-1:0]     waddr;
    logic [NUM_CH*8-1:0] rdata;
    logic [7:0]          resp;
    logic                send_resp;
    logic                clr_cmd_rdy;
    logic [LOG2-1:0]     raddr;

    modport master (
        output cmd, cmd_rdy, resp_sent, waddr, rdata,
        input  resp, send_resp, clr_cmd_rdy, raddr
    );

    modport slave (
        input  cmd, cmd_rdy, resp_sent, waddr, rdata,
        output resp, send_resp, clr_cmd_rdy, raddr
    );
endinterface

// File: rtl/cfg_regfile.sv
// Configuration registers: write decode, reset values, sticky capture-done, read mux and address check.
// Writes land one cycle after wr_en; read data and addr_valid are combinational on addr.
module cfg_regfile
    import cmd_cfg_pkg::*;
#(
    parameter int LOG2   = 9,
    parameter int NUM_CH = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [5:0]          addr,
    input  logic [7:0]          wdata,
    input  logic                set_capture_done,
    output logic [7:0]          rd_data,
    output logic                addr_valid,
    output logic [15:0]         dump_len,
    output logic [LOG2-1:0]     trig_pos,
    output logic [3:0]          decimator,
    output logic [7:0]          VIH,
    output logic [7:0]          VIL,
    output logic [7:0]          matchH,
    output logic [7:0]          matchL,
    output logic [7:0]          maskH,
    output logic [7:0]          maskL,
    output logic [7:0]          baud_cntH,
    output logic [7:0]          baud_cntL,
    output logic [5:0]          TrigCfg,
    output logic [NUM_CH*5-1:0] ChTrigCfg
);

    logic [7:0] trig_pos_h, trig_pos_l, dump_len_h, dump_len_l;

    assign trig_pos = LOG2'({trig_pos_h, trig_pos_l});
    assign dump_len = {dump_len_h, dump_len_l};

    assign addr_valid = (addr == A_TRIG_CFG)
                     || ((addr >= 6'h01) && (addr <= 6'(NUM_CH)))
                     || ((addr >= A_DECIM) && (addr <= A_DUMP_LEN_L));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            TrigCfg    <= 6'h03;
            ChTrigCfg  <= {NUM_CH{5'h01}};
            decimator  <= 4'h0;
            VIH        <= 8'hAA;
            VIL        <= 8'h55;
            matchH     <= 8'h00;
            matchL     <= 8'h00;
            maskH      <= 8'h00;
            maskL      <= 8'h00;
            baud_cntH  <= 8'h06;
            baud_cntL  <= 8'hC8;
            trig_pos_h <= 8'h00;
            trig_pos_l <= 8'h01;
            dump_len_h <= 8'h00;
            dump_len_l <= 8'h00;
        end else begin
            // capture-done goes first so a same-cycle TrigCfg write overrides it
            if (set_capture_done) TrigCfg[5] <= 1'b1;
            if (wr_en) begin
                case (addr)
                    A_TRIG_CFG:   TrigCfg    <= wdata[5:0];
                    A_DECIM:      decimator  <= wdata[3:0];
                    A_VIH:        VIH        <= wdata;
                    A_VIL:        VIL        <= wdata;
                    A_MATCH_H:    matchH     <= wdata;
                    A_MATCH_L:    matchL     <= wdata;
                    A_MASK_H:     maskH      <= wdata;
                    A_MASK_L:     maskL      <= wdata;
                    A_BAUD_H:     baud_cntH  <= wdata;
                    A_BAUD_L:     baud_cntL  <= wdata;
                    A_TRIG_POS_H: trig_pos_h <= wdata;
                    A_TRIG_POS_L: trig_pos_l <= wdata;
                    A_DUMP_LEN_H: dump_len_h <= wdata;
                    A_DUMP_LEN_L: dump_len_l <= wdata;
                    default: ;
                endcase
                for (int i = 0; i < NUM_CH; i++) begin
                    if (addr == 6'(i + 1)) ChTrigCfg[i*5 +: 5] <= wdata[4:0];
                end
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (addr)
            A_TRIG_CFG:   rd_data = {2'b00, TrigCfg};
            A_DECIM:      rd_data = {4'h0, decimator};
            A_VIH:        rd_data = VIH;
            A_VIL:        rd_data = VIL;
            A_MATCH_H:    rd_data = matchH;
            A_MATCH_L:    rd_data = matchL;
            A_MASK_H:     rd_data = maskH;
            A_MASK_L:     rd_data = maskL;
            A_BAUD_H:     rd_data = baud_cntH;
            A_BAUD_L:     rd_data = baud_cntL;
            A_TRIG_POS_H: rd_data = trig_pos_h;
            A_TRIG_POS_L: rd_data = trig_pos_l;
            A_DUMP_LEN_H: rd_data = dump_len_h;
            A_DUMP_LEN_L: rd_data = dump_len_l;
            default: ;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr == 6'(i + 1)) rd_data = {3'b000, ChTrigCfg[i*5 +: 5]};
        end
    end

endmodule

// File: rtl/cmd_cfg_multi.sv
// Logic-analyser host command engine: register read/write and multi-byte channel dump from the RAMqueue.
// Each response byte is held until resp_sent; a command completes with a clr_cmd_rdy pulse.
module cmd_cfg_multi
    import cmd_cfg_pkg::*;
#(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9,
    parameter int NUM_CH  = 5
) (
    input  logic                clk,
    input  logic                rst,
    cmd_cfg_multi_if.slave      bus,
    input  logic                set_capture_done,
    output logic [LOG2-1:0]     trig_pos,
    output logic [3:0]          decimator,
    output logic [7:0]          VIH,
    output logic [7:0]          VIL,
    output logic [7:0]          matchH,
    output logic [7:0]          matchL,
    output logic [7:0]          maskH,
    output logic [7:0]          maskL,
    output logic [7:0]          baud_cntH,
    output logic [7:0]          baud_cntL,
    output logic [5:0]          TrigCfg,
    output logic [NUM_CH*5-1:0] ChTrigCfg
);

    localparam int CW = $clog2(ENTRIES + 1);

    state_t        state;
    logic [CW-1:0] remaining;
    logic [CW-1:0] eff_len;
    logic [2:0]    dump_ch;
    logic          in_dump;
    logic [7:0]    rd_data;
    logic [7:0]    chan_byte;
    logic          addr_valid;
    logic          wr_en;
    logic          ch_ok;
    logic [15:0]   dump_len;
    op_e           op;
    logic [2:0]    cmd_ch;

    assign op     = op_e'(bus.cmd[15:14]);
    assign cmd_ch = bus.cmd[10:8];
    assign ch_ok  = (cmd_ch != 3'd0) && ({1'b0, cmd_ch} <= 4'(NUM_CH));
    assign wr_en  = (state == IDLE) && bus.cmd_rdy && (op == OP_WR) && addr_valid;

    // zero or an over-long length both mean "the whole queue"
    assign eff_len = ((dump_len == 16'd0) || ({1'b0, dump_len} > 17'(ENTRIES)))
                   ? CW'(ENTRIES) : CW'(dump_len);

    always_comb begin
        chan_byte = 8'h00;
        for (int n = 1; n <= NUM_CH; n++) begin
            if (dump_ch == 3'(n)) chan_byte = bus.rdata[(n-1)*8 +: 8];
        end
    end

    cfg_regfile #(.LOG2(LOG2), .NUM_CH(NUM_CH)) u_regs (
        .clk              (clk),
        .rst              (rst),
        .wr_en            (wr_en),
        .addr             (bus.cmd[13:8]),
        .wdata            (bus.cmd[7:0]),
        .set_capture_done (set_capture_done),
        .rd_data          (rd_data),
        .addr_valid       (addr_valid),
        .dump_len         (dump_len),
        .trig_pos         (trig_pos),
        .decimator        (decimator),
        .VIH              (VIH),
        .VIL              (VIL),
        .matchH           (matchH),
        .matchL           (matchL),
        .maskH            (maskH),
        .maskL            (maskL),
        .baud_cntH        (baud_cntH),
        .baud_cntL        (baud_cntL),
        .TrigCfg          (TrigCfg),
        .ChTrigCfg        (ChTrigCfg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            bus.resp        <= 8'h00;
            bus.send_resp   <= 1'b0;
            bus.clr_cmd_rdy <= 1'b0;
            bus.raddr       <= '0;
            remaining       <= '0;
            dump_ch         <= 3'd0;
            in_dump         <= 1'b0;
        end else begin
            bus.send_resp   <= 1'b0;
            bus.clr_cmd_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_rdy) begin
                        in_dump <= 1'b0;
                        state   <= RESP;
                        bus.send_resp <= 1'b1;
                        bus.resp      <= NAK;
                        case (op)
                            OP_RD:   if (addr_valid) bus.resp <= rd_data;
                            OP_WR:   if (addr_valid) bus.resp <= ACK;
                            OP_DUMP: begin
                                if (ch_ok) begin
                                    bus.send_resp <= 1'b0;
                                    bus.raddr     <= bus.waddr;
                                    remaining     <= eff_len;
                                    dump_ch       <= cmd_ch;
                                    in_dump       <= 1'b1;
                                    state         <= RD_WAIT;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                RD_WAIT: state <= SEND;
                SEND: begin
                    bus.resp      <= chan_byte;
                    bus.send_resp <= 1'b1;
                    remaining     <= remaining - 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.resp_sent) begin
                        if (in_dump && (remaining != '0)) begin
                            bus.raddr <= (bus.raddr == LOG2'(ENTRIES - 1)) ? '0 : bus.raddr + 1'b1;
                            state     <= RD_WAIT;
                        end else begin
                            bus.clr_cmd_rdy <= 1'b1;
                            state           <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_cfg_multi.sv
// Directed bench for cmd_cfg_multi with a 1-cycle-latency RAMqueue model.
module tb_cmd_cfg_multi;

    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;
    localparam int NUM_CH  = 5;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                set_capture_done = 1'b0;
    logic [LOG2-1:0]     trig_pos;
    logic [3:0]          decimator;
    logic [7:0]          VIH, VIL, matchH, matchL, maskH, maskL, baud_cntH, baud_cntL;
    logic [5:0]          TrigCfg;
    logic [NUM_CH*5-1:0] ChTrigCfg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got[$];
    int         addrs[$];

    cmd_cfg_multi_if #(.LOG2(LOG2), .NUM_CH(NUM_CH)) bus ();

    cmd_cfg_multi #(.ENTRIES(ENTRIES), .LOG2(LOG2), .NUM_CH(NUM_CH)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .set_capture_done (set_capture_done),
        .trig_pos         (trig_pos),
        .decimator        (decimator),
        .VIH              (VIH),
        .VIL              (VIL),
        .matchH           (matchH),
        .matchL           (matchL),
        .maskH            (maskH),
        .maskL            (maskL),
        .baud_cntH        (baud_cntH),
        .baud_cntL        (baud_cntL),
        .TrigCfg          (TrigCfg),
        .ChTrigCfg        (ChTrigCfg)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_byte(input int a, input int c);
        return 8'((a * 13 + c * 71 + (a >> 4)) & 255);
    endfunction

    always @(posedge clk) begin
        for (int c = 1; c <= NUM_CH; c++)
            bus.rdata[(c-1)*8 +: 8] <= ram_byte(int'(bus.raddr), c);
    end

    // issue one command, acknowledge every byte immediately, stop at clr_cmd_rdy
    task automatic run_cmd(input logic [15:0] c, input int max_cyc, output int timed_out);
        bus.cmd = c;
        bus.cmd_rdy = 1'b1;
        got.delete();
        addrs.delete();
        timed_out = 1;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk); #1;
            bus.resp_sent = 1'b0;
            if (bus.send_resp) begin
                got.push_back(bus.resp);
                addrs.push_back(int'(bus.raddr));
                bus.resp_sent = 1'b1;
            end
            if (bus.clr_cmd_rdy) begin
                bus.cmd_rdy = 1'b0;
                timed_out = 0;
                break;
            end
        end
        bus.resp_sent = 1'b0;
        bus.cmd_rdy = 1'b0;
    endtask

    // single-byte command: one response byte and completion expected
    task automatic single(input string name, input logic [15:0] c, input logic [7:0] exp);
        int to;
        run_cmd(c, 20, to);
        n_checks++;
        if (to != 0 || got.size() != 1) begin
            n_fail++;
            $display("FAIL %s: timeout=%0d bytes=%0d, required 1 byte then clr_cmd_rdy", name, to, got.size());
        end else begin
            n_checks++;
            if (got[0] !== exp) begin
                n_fail++;
                $display("FAIL %s: resp=%h required %h", name, got[0], exp);
            end
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({bus.resp, bus.send_resp, bus.clr_cmd_rdy} !== 10'h0 || bus.raddr !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: resp=%h send=%b clr=%b raddr=%0d required 0", bus.resp, bus.send_resp, bus.clr_cmd_rdy, bus.raddr);
        end
        n_checks++;
        if (TrigCfg !== 6'h03 || ChTrigCfg !== {NUM_CH{5'h01}} || decimator !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_cfg: TrigCfg=%h ChTrigCfg=%h dec=%h required 03 %h 0", TrigCfg, ChTrigCfg, decimator, {NUM_CH{5'h01}});
        end
        n_checks++;
        if ({VIH, VIL, matchH, matchL, maskH, maskL, baud_cntH, baud_cntL} !== 64'hAA55_0000_0000_06C8 || trig_pos !== 9'd1) begin
            n_fail++;
            $display("FAIL reset_regs: %h %h %h %h %h %h %h %h trig_pos=%h", VIH, VIL, matchH, matchL, maskH, maskL, baud_cntH, baud_cntL, trig_pos);
        end
    endtask

    task automatic test_read();
        single("read_trigcfg", 16'h0000, 8'h03);
        single("read_baud_l", 16'h1800, 8'hC8);
        single("read_ch1", 16'h0100, 8'h01);
    endtask

    task automatic test_write_bounds();
        single("wr_addr_0b", 16'h4BC3, 8'hEE);
        single("wr_addr_07", 16'h4711, 8'hEE);
        n_checks++;
        if (VIH !== 8'hAA || ChTrigCfg !== {NUM_CH{5'h01}}) begin
            n_fail++;
            $display("FAIL nak_no_change: VIH=%h ChTrigCfg=%h required AA %h", VIH, ChTrigCfg, {NUM_CH{5'h01}});
        end
        single("wr_vih", 16'h5122, 8'hA5);
        n_checks++;
        if (VIH !== 8'h22) begin
            n_fail++;
            $display("FAIL vih_value: VIH=%h required 22", VIH);
        end
        single("rd_vih", 16'h1100, 8'h22);
        single("op11", 16'hC000, 8'hEE);
        single("rd_invalid_1d", 16'h1D00, 8'hEE);
        single("wr_decim", 16'h50F9, 8'hA5);
        single("rd_decim", 16'h1000, 8'h09);
        single("wr_trig_pos_h", 16'h5901, 8'hA5);
        single("wr_trig_pos_l", 16'h5A23, 8'hA5);
        n_checks++;
        if (trig_pos !== 9'h123) begin
            n_fail++;
            $display("FAIL trig_pos: trig_pos=%h required 123", trig_pos);
        end
    endtask

    task automatic test_channels();
        single("wr_ch6", 16'h4606, 8'hEE);
        single("wr_ch5", 16'h4513, 8'hA5);
        n_checks++;
        if (ChTrigCfg !== {5'h13, {(NUM_CH-1){5'h01}}}) begin
            n_fail++;
            $display("FAIL ch5_cfg: ChTrigCfg=%h required %h", ChTrigCfg, {5'h13, {(NUM_CH-1){5'h01}}});
        end
        single("rd_ch5", 16'h0500, 8'h13);
        single("dump_ch6", 16'h8600, 8'hEE);
        single("dump_ch0", 16'h8000, 8'hEE);
    endtask

    task automatic test_dump_short();
        int to;
        int exp_a[4] = '{382, 383, 0, 1};
        int bad = 0;
        single("wr_len_l4", 16'h5C04, 8'hA5);
        bus.waddr = 9'd382;
        run_cmd(16'h8200, 100, to);
        bus.waddr = 9'd0;
        n_checks++;
        if (to != 0 || got.size() != 4) begin
            n_fail++;
            $display("FAIL dump4_count: timeout=%0d bytes=%0d required 4", to, got.size());
        end else begin
            for (int i = 0; i < 4; i++)
                if (addrs[i] != exp_a[i] || got[i] !== ram_byte(exp_a[i], 2)) bad++;
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL dump4_data: %0d of 4 bytes/addresses wrong, required 0", bad);
            end
        end
    endtask

    task automatic long_dump(input string name, input logic [15:0] c, input int start, input int ch);
        int to;
        int bad = 0;
        bus.waddr = LOG2'(start);
        run_cmd(c, 2000, to);
        n_checks++;
        if (to != 0 || got.size() != ENTRIES) begin
            n_fail++;
            $display("FAIL %s_count: timeout=%0d bytes=%0d required %0d", name, to, got.size(), ENTRIES);
        end else begin
            for (int i = 0; i < ENTRIES; i++)
                if (addrs[i] != (start + i) % ENTRIES || got[i] !== ram_byte((start + i) % ENTRIES, ch)) bad++;
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL %s_data: %0d wrong bytes/addresses, required 0", name, bad);
            end
        end
    endtask

    task automatic test_dump_len();
        single("wr_len_l0", 16'h5C00, 8'hA5);
        long_dump("dump_len0", 16'h8500, 10, 5);
        single("wr_len_h1", 16'h5B01, 8'hA5);
        single("wr_len_l81", 16'h5C81, 8'hA5);
        long_dump("dump_len385", 16'h8100, 0, 1);
    endtask

    task automatic test_capture_done();
        set_capture_done = 1'b1;
        @(posedge clk); #1;
        set_capture_done = 1'b0;
        n_checks++;
        if (TrigCfg !== 6'h23) begin
            n_fail++;
            $display("FAIL capture_set: TrigCfg=%h required 23", TrigCfg);
        end
        @(posedge clk); #1;
        n_checks++;
        if (TrigCfg !== 6'h23) begin
            n_fail++;
            $display("FAIL capture_sticky: TrigCfg=%h required 23", TrigCfg);
        end
        bus.cmd = 16'h4003;
        bus.cmd_rdy = 1'b1;
        set_capture_done = 1'b1;
        @(posedge clk); #1;
        set_capture_done = 1'b0;
        n_checks++;
        if (TrigCfg !== 6'h03 || bus.send_resp !== 1'b1 || bus.resp !== 8'hA5) begin
            n_fail++;
            $display("FAIL write_wins: TrigCfg=%h send=%b resp=%h required 03 1 A5", TrigCfg, bus.send_resp, bus.resp);
        end
        bus.resp_sent = 1'b1;
        @(posedge clk); #1;
        bus.resp_sent = 1'b0;
        n_checks++;
        if (bus.clr_cmd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL write_wins_clr: clr_cmd_rdy=%b required 1", bus.clr_cmd_rdy);
        end
        bus.cmd_rdy = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_dump();
        int pulses = 0;
        int extra = 0;
        single("wr_len_l4b", 16'h5C04, 8'hA5);
        bus.waddr = 9'd100;
        bus.cmd = 16'h8300;
        bus.cmd_rdy = 1'b1;
        for (int i = 0; i < 60 && pulses < 3; i++) begin
            @(posedge clk); #1;
            bus.resp_sent = 1'b0;
            if (bus.send_resp) begin
                pulses++;
                if (pulses < 3) bus.resp_sent = 1'b1;
            end
        end
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL mid_dump_reach: pulses=%0d required 3", pulses);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.send_resp !== 1'b0 || bus.raddr !== '0 || bus.resp !== 8'h00 || VIH !== 8'hAA) begin
            n_fail++;
            $display("FAIL mid_dump_rst: send=%b raddr=%0d resp=%h VIH=%h required 0 0 00 AA", bus.send_resp, bus.raddr, bus.resp, VIH);
        end
        bus.cmd_rdy = 1'b0;
        bus.resp_sent = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus.send_resp || bus.clr_cmd_rdy) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL mid_dump_quiet: %0d send/clr pulses after reset, required 0", extra);
        end
        single("post_rst_vih", 16'h1100, 8'hAA);
    endtask

    initial begin
        bus.cmd = 16'h0;
        bus.cmd_rdy = 1'b0;
        bus.resp_sent = 1'b0;
        bus.waddr = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_read();
        test_write_bounds();
        test_channels();
        test_dump_short();
        test_dump_len();
        test_capture_done();
        test_reset_mid_dump();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
